// File: rtl/igbt_scr_pkg.sv
// Shared types, channel count, timing defaults and on-time clamp for the
// IGBT/SCR firing sequencer.
package igbt_scr_pkg;

  localparam int NUM_CH        = 5;
  localparam int TICK_DIV_DEF  = 50;
  localparam int SCR_US_DEF    = 10;
  localparam int DEAD_US_DEF   = 100;
  localparam int MAX_ON_US_DEF = 1000;
  localparam int TMR_W         = 16;

  typedef enum logic [2:0] {
    IDLE,
    ON,
    SCR,
    DEAD,
    FAULT
  } state_t;

  // A zero on-time would never expire, so it is raised to the shortest pulse.
  function automatic logic [TMR_W-1:0] clamp_on_us(input logic [31:0] raw,
                                                   input int max_us);
    if (raw == 32'd0) return TMR_W'(1);
    if (raw > 32'(max_us)) return TMR_W'(max_us);
    return raw[TMR_W-1:0];
  endfunction

endpackage

// File: rtl/us_timer.sv
// Microsecond phase timer: prescaler to 1 us ticks plus a us down-counter.
// The cycle in which load is high counts as prescaler count 0 of the new phase.
module us_timer #(
  parameter int TICK_DIV = 50,
  parameter int W        = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;
  logic [W-1:0]  cnt;
  logic          tick;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign expire = !load && tick && (cnt == W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (load) begin
      presc <= PW'(1);
      cnt   <= load_value;
    end else if (tick) begin
      presc <= '0;
      if (cnt != '0) cnt <= cnt - W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/igbt_scr_sequencer.sv
// Round-robin arbiter and firing FSM for the shared five-channel IGBT/SCR
// drive stage: IGBT on-time, SCR trigger, dead time, sticky fault shutdown.
module igbt_scr_sequencer
  import igbt_scr_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int ON_W      = 16,
  parameter int MAX_ON_US = MAX_ON_US_DEF,
  parameter int SCR_US    = SCR_US_DEF,
  parameter int DEAD_US   = DEAD_US_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   enable,
  input  logic [NUM_CH-1:0]      req,
  input  logic [NUM_CH*ON_W-1:0] on_us,
  input  logic                   fault,
  input  logic                   fault_clr,
  output logic [NUM_CH-1:0]      ack,
  output logic [NUM_CH-1:0]      IGBT_on_EN,
  output logic [NUM_CH-1:0]      SCR_trig,
  output logic                   busy,
  output logic                   done,
  output logic                   fault_latched
);

  state_t           state;
  logic [2:0]       ch;
  logic [2:0]       ptr;
  logic [2:0]       pick;
  logic [2:0]       ptr_next;
  logic [TMR_W-1:0] pick_on;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_load;
  logic             expire;
  logic             fire_ok;

  // Scanning offsets high to low leaves the closest requester at/after p.
  function automatic logic [2:0] rr_pick(input logic [NUM_CH-1:0] r,
                                         input logic [2:0] p);
    logic [2:0] sel;
    logic [2:0] idx;
    sel = p;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(p) + i >= NUM_CH) ? 3'(int'(p) + i - NUM_CH) : 3'(int'(p) + i);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

  function automatic logic [NUM_CH-1:0] ch_mask(input logic [2:0] c);
    return NUM_CH'(1) << c;
  endfunction

  assign pick     = rr_pick(req, ptr);
  assign ptr_next = (pick == 3'(NUM_CH - 1)) ? 3'd0 : pick + 3'd1;
  assign pick_on  = clamp_on_us(32'(on_us[pick*ON_W +: ON_W]), MAX_ON_US);

  us_timer #(
    .TICK_DIV (TICK_DIV),
    .W        (TMR_W)
  ) u_timer (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .expire     (expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      ch            <= '0;
      ptr           <= '0;
      ack           <= '0;
      IGBT_on_EN    <= '0;
      SCR_trig      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault_latched <= 1'b0;
      fire_ok       <= 1'b0;
      tmr_load      <= 1'b0;
      tmr_val       <= '0;
    end else begin
      ack      <= '0;
      done     <= 1'b0;
      tmr_load <= 1'b0;
      if (fault) begin
        state         <= FAULT;
        IGBT_on_EN    <= '0;
        SCR_trig      <= '0;
        busy          <= 1'b1;
        fault_latched <= 1'b1;
        fire_ok       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (enable && !fault_latched && (|req)) begin
              ch         <= pick;
              ptr        <= ptr_next;
              ack        <= ch_mask(pick);
              IGBT_on_EN <= ch_mask(pick);
              busy       <= 1'b1;
              tmr_load   <= 1'b1;
              tmr_val    <= pick_on;
              state      <= ON;
            end
          end
          ON: begin
            if (!enable) begin
              IGBT_on_EN <= '0;
              fire_ok    <= 1'b0;
              tmr_load   <= 1'b1;
              tmr_val    <= TMR_W'(DEAD_US);
              state      <= DEAD;
            end else if (expire) begin
              IGBT_on_EN <= '0;
              SCR_trig   <= ch_mask(ch);
              tmr_load   <= 1'b1;
              tmr_val    <= TMR_W'(SCR_US);
              state      <= SCR;
            end
          end
          SCR: begin
            if (!enable || expire) begin
              SCR_trig <= '0;
              fire_ok  <= enable;
              tmr_load <= 1'b1;
              tmr_val  <= TMR_W'(DEAD_US);
              state    <= DEAD;
            end
          end
          DEAD: begin
            if (expire) begin
              done    <= fire_ok;
              fire_ok <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
          FAULT: begin
            if (fault_clr) begin
              fault_latched <= 1'b0;
              tmr_load      <= 1'b1;
              tmr_val       <= TMR_W'(DEAD_US);
              state         <= DEAD;
            end
          end
          default: begin
            IGBT_on_EN <= '0;
            SCR_trig   <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_igbt_scr_sequencer.sv
// Scoreboarded bench for igbt_scr_sequencer: each expected firing is queued at
// stimulus time and compared against the measured firing when done pulses.
module tb_igbt_scr_sequencer;

  localparam int TICK     = 50;
  localparam int ON_W     = 16;
  localparam int MAX_ON   = 100;
  localparam int SCR_US   = 10;
  localparam int DEAD_US  = 100;
  localparam int SCR_CYC  = SCR_US * TICK;
  localparam int DEAD_CYC = DEAD_US * TICK;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            enable    = 1'b0;
  logic            fault     = 1'b0;
  logic            fault_clr = 1'b0;
  logic [4:0]      req       = '0;
  logic [5*ON_W-1:0] on_us   = '0;
  logic [4:0]      ack;
  logic [4:0]      IGBT_on_EN;
  logic [4:0]      SCR_trig;
  logic            busy;
  logic            done;
  logic            fault_latched;

  always #10 sys_clk = ~sys_clk;

  igbt_scr_sequencer #(
    .TICK_DIV  (TICK),
    .ON_W      (ON_W),
    .MAX_ON_US (MAX_ON),
    .SCR_US    (SCR_US),
    .DEAD_US   (DEAD_US)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .enable        (enable),
    .req           (req),
    .on_us         (on_us),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .ack           (ack),
    .IGBT_on_EN    (IGBT_on_EN),
    .SCR_trig      (SCR_trig),
    .busy          (busy),
    .done          (done),
    .fault_latched (fault_latched)
  );

  typedef struct {
    int ch;
    int igbt_n;
    int scr_n;
    int dead_n;
    bit chk_gap;
  } firing_t;

  firing_t exp_q[$];
  firing_t exp_f;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int cur_ch, grant_cyc, grant_gap, igbt_n, scr_n, last_scr;
  int last_done = -100000;
  int grant_cnt = 0;
  int done_cnt  = 0;
  bit overlap, wrong_ch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int ch_of(input logic [4:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 5; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Firing monitor: measures each firing and scores it on done.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (|ack) begin
        cur_ch    = ch_of(ack);
        grant_cyc = cyc;
        grant_gap = cyc - last_done;
        igbt_n    = 0;
        scr_n     = 0;
        last_scr  = cyc;
        overlap   = 1'b0;
        wrong_ch  = 1'b0;
        grant_cnt++;
        check("ack_onehot", 64'($onehot(ack)), 1);
        check("igbt_with_ack", IGBT_on_EN, ack);
      end
      if (|IGBT_on_EN) begin
        igbt_n++;
        if (IGBT_on_EN != (5'd1 << cur_ch)) wrong_ch = 1'b1;
      end
      if (|SCR_trig) begin
        scr_n++;
        last_scr = cyc;
        if (SCR_trig != (5'd1 << cur_ch)) wrong_ch = 1'b1;
      end
      if ((|IGBT_on_EN) && (|SCR_trig)) overlap = 1'b1;
      if (done) begin
        done_cnt++;
        last_done = cyc;
        check("done_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_f = exp_q.pop_front();
          check("fire_ch", cur_ch, exp_f.ch);
          check("fire_igbt_len", igbt_n, exp_f.igbt_n);
          check("fire_scr_len", scr_n, exp_f.scr_n);
          check("fire_dead_len", cyc - last_scr - 1, exp_f.dead_n);
          check("fire_overlap", overlap, 0);
          check("fire_wrong_ch", wrong_ch, 0);
          if (exp_f.chk_gap) check("fire_grant_gap", grant_gap, 1);
        end
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    while (grant_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    check("grant_wait", 64'(grant_cnt >= target), 1);
  endtask

  task automatic wait_dones(input int target, input int budget);
    while (done_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    check("done_wait", 64'(done_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget, output int at);
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    check("idle_wait", busy, 0);
    at = cyc;
  endtask

  localparam int FIRE_MAX = MAX_ON * TICK + SCR_CYC + DEAD_CYC + 20;

  initial begin
    int g0, d0, t, t_idle, n;

    // Reset state
    repeat (3) step();
    check("rst_ack", ack, 0);
    check("rst_igbt", IGBT_on_EN, 0);
    check("rst_scr", SCR_trig, 0);
    check("rst_flags", {busy, done, fault_latched}, 0);
    sys_rst_n = 1'b1;
    repeat (2) step();

    // Basic firing on channel 0, on_us = 3
    enable = 1'b1;
    on_us[0*ON_W +: ON_W] = 16'd3;
    exp_q.push_back('{0, 3 * TICK, SCR_CYC, DEAD_CYC, 1'b0});
    g0 = grant_cnt;
    d0 = done_cnt;
    req = 5'b00001;
    t = cyc;
    wait_grants(g0 + 1, 10);
    check("basic_latency", grant_cyc - t, 1);
    check("basic_busy", busy, 1);
    req = '0;
    wait_dones(d0 + 1, FIRE_MAX);

    // Asynchronous reset in the middle of an ON phase
    on_us[2*ON_W +: ON_W] = 16'd3;
    g0 = grant_cnt;
    req = 5'b00100;
    wait_grants(g0 + 1, 10);
    req = '0;
    repeat (20) step();
    check("pre_rst_igbt", IGBT_on_EN, 5'b00100);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_igbt", IGBT_on_EN, 0);
    check("async_rst_scr", SCR_trig, 0);
    check("async_rst_busy", busy, 0);
    step();
    sys_rst_n = 1'b1;
    step();
    check("post_rst_outputs", {busy, IGBT_on_EN, SCR_trig}, 0);

    // Round robin: all channels requesting, pointer starts at 0 after reset
    for (int k = 0; k < 5; k++) on_us[k*ON_W +: ON_W] = 16'd1;
    g0 = grant_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) exp_q.push_back('{i % 5, TICK, SCR_CYC, DEAD_CYC, i > 0});
    req = 5'b11111;
    wait_grants(g0 + 6, 6 * FIRE_MAX);
    req = '0;
    wait_dones(d0 + 6, FIRE_MAX);

    // Clamp: zero on-time
    on_us[3*ON_W +: ON_W] = 16'd0;
    g0 = grant_cnt;
    d0 = done_cnt;
    exp_q.push_back('{3, TICK, SCR_CYC, DEAD_CYC, 1'b0});
    req = 5'b01000;
    wait_grants(g0 + 1, 10);
    req = '0;
    wait_dones(d0 + 1, FIRE_MAX);

    // Clamp: above maximum, and on_us changed after grant has no effect
    on_us[2*ON_W +: ON_W] = 16'd5000;
    g0 = grant_cnt;
    d0 = done_cnt;
    exp_q.push_back('{2, MAX_ON * TICK, SCR_CYC, DEAD_CYC, 1'b0});
    req = 5'b00100;
    wait_grants(g0 + 1, 10);
    req = '0;
    on_us[2*ON_W +: ON_W] = 16'd1;
    wait_dones(d0 + 1, FIRE_MAX);

    // Fault at cycle 40 of ON
    on_us[1*ON_W +: ON_W] = 16'd3;
    g0 = grant_cnt;
    d0 = done_cnt;
    req = 5'b00010;
    wait_grants(g0 + 1, 10);
    req = '0;
    repeat (39) step();
    check("pre_fault_igbt", IGBT_on_EN, 5'b00010);
    fault = 1'b1;
    step();
    check("fault_igbt_off", IGBT_on_EN, 0);
    check("fault_latched_set", fault_latched, 1);
    check("fault_busy", busy, 1);
    repeat (5) step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_ignored_latched", fault_latched, 1);
    repeat (3) step();
    fault = 1'b0;
    step();
    check("fault_still_latched", fault_latched, 1);
    fault_clr = 1'b1;
    t = cyc;
    step();
    fault_clr = 1'b0;
    check("fault_cleared", fault_latched, 0);
    check("fault_dead_busy", busy, 1);
    wait_idle(DEAD_CYC + 20, t_idle);
    check("fault_dead_len", t_idle - t, DEAD_CYC + 1);
    check("fault_no_scr", scr_n, 0);
    check("fault_no_done", done_cnt, d0);

    // Abort during SCR
    on_us[4*ON_W +: ON_W] = 16'd1;
    on_us[0*ON_W +: ON_W] = 16'd1;
    g0 = grant_cnt;
    d0 = done_cnt;
    req = 5'b10000;
    wait_grants(g0 + 1, 10);
    req = 5'b00001;
    n = 0;
    while (!(|SCR_trig) && n < TICK + 10) begin
      step();
      n++;
    end
    check("abort_scr_seen", SCR_trig, 5'b10000);
    repeat (5) step();
    enable = 1'b0;
    t = cyc;
    step();
    check("abort_scr_off", SCR_trig, 0);
    check("abort_busy", busy, 1);
    wait_idle(DEAD_CYC + 20, t_idle);
    check("abort_dead_len", t_idle - t, DEAD_CYC + 1);
    check("abort_no_done", done_cnt, d0);
    repeat (100) step();
    check("abort_req_blocked", grant_cnt, g0 + 1);
    exp_q.push_back('{0, TICK, SCR_CYC, DEAD_CYC, 1'b0});
    enable = 1'b1;
    t = cyc;
    wait_grants(g0 + 2, 10);
    check("reenable_latency", grant_cyc - t, 1);
    req = '0;
    wait_dones(d0 + 1, FIRE_MAX);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
